// File: rtl/sd_spi_responder.sv
`timescale 1ns/1ps
// sd_spi_responder
// Stand-in for an SPI-mode SD card. It answers CMD0, CMD8, CMD55/ACMD41,
// CMD58, CMD16, CMD17 and CMD24, and serves 512-byte sectors from an external
// byte-wide backing store.
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   sdSCLK/sdMOSI/sdCS  SPI pins from the host (mode 0, CS active-low)
//   sdMISO              SPI data to the host, MSB first
//   memADDR/memRD/      backing-store read; memRDATA is valid the clk after memRD
//   memRDATA
//   memWR/memWDATA      backing-store write strobe and data
//   rdCNT/wrCNT         completed CMD17 / CMD24 counts (wrap at 255)
//   idle                card idle flag (R1 bit 0)
module sd_spi_responder #(
  parameter int ADDR_W     = 24,
  parameter int INIT_POLLS = 2,
  parameter int RD_LATENCY = 4,
  parameter int WR_BUSY    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sdSCLK,
  input  logic              sdMOSI,
  input  logic              sdCS,
  output logic              sdMISO,
  output logic [ADDR_W-1:0] memADDR,
  output logic              memRD,
  input  logic [7:0]        memRDATA,
  output logic              memWR,
  output logic [7:0]        memWDATA,
  output logic [7:0]        rdCNT,
  output logic [7:0]        wrCNT,
  output logic              idle
);
  localparam int         SEC_W      = ADDR_W - 9;
  localparam logic [7:0] POLL_LIMIT = 8'(INIT_POLLS);
  localparam logic [7:0] RD_LAST    = 8'(RD_LATENCY - 1);
  localparam logic [7:0] BUSY_LAST  = 8'(WR_BUSY - 1);

  typedef enum logic [3:0] {
    S_CMD, S_NCR, S_R1, S_RX4,
    S_RD_WAIT, S_RD_TOKEN, S_RD_DATA, S_RD_CRC,
    S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
  } state_t;

  // What follows the R1 byte of the command being answered.
  typedef enum logic [1:0] {K_NONE, K_TRAIL, K_READ, K_WRITE} kind_t;

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic cs_meta_q, cs_sync_q;

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_sr_q, rx_sr_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic              miso_q, miso_d;
  logic [2:0]        cmd_cnt_q, cmd_cnt_d;
  logic [37:0]       cmd_sr_q, cmd_sr_d;
  logic [7:0]        r1_q, r1_d;
  logic [31:0]       trail_q, trail_d;
  logic [SEC_W-1:0]  sector_q, sector_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [8:0]        idx_q, idx_d;
  logic              rd_vld_q, rd_vld_d;
  logic [7:0]        rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        rd_cnt_q, rd_cnt_d;
  logic [7:0]        wr_cnt_q, wr_cnt_d;
  logic              idle_q, idle_d;
  logic              app_q, app_d;
  logic [7:0]        polls_q, polls_d;

  logic        sclk_rise, sclk_fall, byte_done;
  logic [7:0]  rx_byte;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        out_of_range;

  assign sclk_rise    = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall    = ~sclk_sync_q & sclk_prev_q;
  assign rx_byte      = {rx_sr_q, mosi_sync_q};
  // The command shifter keeps only the low 6 bits of the first byte (the index).
  assign cmd_idx      = cmd_sr_q[37:32];
  assign cmd_arg      = cmd_sr_q[31:0];
  assign out_of_range = (cmd_arg >> SEC_W) != 32'd0;

  always_comb begin
    // NOTE: every *_d defaults to its flop (or an idle value) before any branch, so no path leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    kind_d      = kind_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    cmd_cnt_d   = cmd_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    r1_d        = r1_q;
    trail_d     = trail_q;
    sector_d    = sector_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rd_vld_d    = mem_rd_q;
    rd_buf_d    = rd_vld_q ? memRDATA : rd_buf_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    idle_d      = idle_q;
    app_d       = app_q;
    polls_d     = polls_q;
    byte_done   = 1'b0;

    if (cs_sync_q) begin
      bit_cnt_d = 3'd0;
      cmd_cnt_d = 3'd0;
      // A busy countdown survives CS high; the interrupted busy byte restarts.
      if (state_q == S_WR_BUSY) begin
        tx_sr_d = 8'h00;
      end else begin
        state_d = S_CMD;
        tx_sr_d = 8'hFF;
      end
    end else begin
      // No shift on the falling edge that directly follows a byte load.
      if (sclk_fall && bit_cnt_q != 3'd0) tx_sr_d = {tx_sr_q[6:0], 1'b1};
      if (sclk_rise) begin
        rx_sr_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_done = (bit_cnt_q == 3'd7);
        // Prefetch the next data byte on the first edge of the preceding byte.
        if (bit_cnt_q == 3'd0 && state_q == S_RD_TOKEN) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = {sector_q, 9'd0};
        end else if (bit_cnt_q == 3'd0 && state_q == S_RD_DATA && idx_q != 9'd511) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = {sector_q, idx_q + 9'd1};
        end
      end

      if (byte_done) begin
        tx_sr_d = 8'hFF;
        case (state_q)
          S_CMD: begin
            if (cmd_cnt_q == 3'd0 && rx_byte[7:6] != 2'b01) begin
              // Not a command start; keep discarding.
            end else if (cmd_cnt_q != 3'd5) begin
              cmd_sr_d  = {cmd_sr_q[29:0], rx_byte};
              cmd_cnt_d = cmd_cnt_q + 3'd1;
            end else begin
              // 6th byte is the CRC, which is ignored; decode now.
              cmd_cnt_d = 3'd0;
              state_d   = S_NCR;
              kind_d    = K_NONE;
              app_d     = 1'b0;
              r1_d      = 8'h04 | {7'd0, idle_q};
              case (cmd_idx)
                6'd0: begin
                  polls_d = 8'd0;
                  idle_d  = 1'b1;
                  r1_d    = 8'h01;
                end
                6'd8: begin
                  r1_d    = {7'd0, idle_q};
                  trail_d = {16'h0000, 8'h01, cmd_arg[7:0]};
                  kind_d  = K_TRAIL;
                end
                6'd55: begin
                  app_d = 1'b1;
                  r1_d  = {7'd0, idle_q};
                end
                6'd41: begin
                  if (app_q) begin
                    if (polls_q != 8'hFF) polls_d = polls_q + 8'd1;
                    if (polls_q < POLL_LIMIT) begin
                      r1_d = 8'h01;
                    end else begin
                      idle_d = 1'b0;
                      r1_d   = 8'h00;
                    end
                  end
                end
                6'd58: begin
                  r1_d    = {7'd0, idle_q};
                  trail_d = 32'hC0FF_8000;
                  kind_d  = K_TRAIL;
                end
                6'd16: r1_d = {7'd0, idle_q};
                6'd17, 6'd24: begin
                  if (idle_q) begin
                    r1_d = 8'h05;
                  end else if (out_of_range) begin
                    r1_d = 8'h40;
                  end else begin
                    r1_d     = 8'h00;
                    sector_d = cmd_arg[SEC_W-1:0];
                    kind_d   = (cmd_idx == 6'd17) ? K_READ : K_WRITE;
                  end
                end
                default: ;
              endcase
            end
          end
          S_NCR: begin
            tx_sr_d = r1_q;
            state_d = S_R1;
          end
          S_R1: begin
            cnt_d = 8'd0;
            case (kind_q)
              K_TRAIL: begin
                tx_sr_d = trail_q[31:24];
                trail_d = {trail_q[23:0], 8'hFF};
                state_d = S_RX4;
              end
              K_READ:  state_d = S_RD_WAIT;
              K_WRITE: state_d = S_WR_TOKEN;
              default: state_d = S_CMD;
            endcase
          end
          S_RX4: begin
            if (cnt_q == 8'd3) begin
              state_d = S_CMD;
            end else begin
              cnt_d   = cnt_q + 8'd1;
              tx_sr_d = trail_q[31:24];
              trail_d = {trail_q[23:0], 8'hFF};
            end
          end
          S_RD_WAIT: begin
            if (cnt_q == RD_LAST) begin
              tx_sr_d = 8'hFE;
              state_d = S_RD_TOKEN;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          S_RD_TOKEN: begin
            tx_sr_d = rd_buf_q;
            idx_d   = 9'd0;
            state_d = S_RD_DATA;
          end
          S_RD_DATA: begin
            if (idx_q == 9'd511) begin
              cnt_d   = 8'd0;
              state_d = S_RD_CRC;
            end else begin
              idx_d   = idx_q + 9'd1;
              tx_sr_d = rd_buf_q;
            end
          end
          S_RD_CRC: begin
            if (cnt_q == 8'd1) begin
              rd_cnt_d = rd_cnt_q + 8'd1;
              state_d  = S_CMD;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          S_WR_TOKEN: begin
            if (rx_byte == 8'hFE) begin
              idx_d   = 9'd0;
              state_d = S_WR_DATA;
            end else if (rx_byte != 8'hFF) begin
              state_d = S_CMD;
            end
          end
          S_WR_DATA: begin
            mem_wr_d    = 1'b1;
            mem_addr_d  = {sector_q, idx_q};
            mem_wdata_d = rx_byte;
            if (idx_q == 9'd511) begin
              cnt_d   = 8'd0;
              state_d = S_WR_CRC;
            end else begin
              idx_d = idx_q + 9'd1;
            end
          end
          S_WR_CRC: begin
            if (cnt_q == 8'd1) begin
              tx_sr_d  = 8'h05;
              wr_cnt_d = wr_cnt_q + 8'd1;
              state_d  = S_WR_RESP;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          S_WR_RESP: begin
            tx_sr_d = 8'h00;
            cnt_d   = 8'd0;
            state_d = S_WR_BUSY;
          end
          S_WR_BUSY: begin
            if (cnt_q == BUSY_LAST) begin
              state_d = S_CMD;
            end else begin
              cnt_d   = cnt_q + 8'd1;
              tx_sr_d = 8'h00;
            end
          end
          default: state_d = S_CMD;
        endcase
      end
    end

    miso_d = cs_sync_q ? 1'b1 : tx_sr_d[7];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      sclk_meta_q <= 1'b0;  sclk_sync_q <= 1'b0;  sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b1;  mosi_sync_q <= 1'b1;
      cs_meta_q   <= 1'b1;  cs_sync_q   <= 1'b1;
      state_q     <= S_CMD;
      kind_q      <= K_NONE;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      tx_sr_q     <= 8'hFF;
      miso_q      <= 1'b1;
      cmd_cnt_q   <= 3'd0;
      cmd_sr_q    <= 38'd0;
      r1_q        <= 8'hFF;
      trail_q     <= 32'hFFFF_FFFF;
      sector_q    <= '0;
      cnt_q       <= 8'd0;
      idx_q       <= 9'd0;
      rd_vld_q    <= 1'b0;
      rd_buf_q    <= 8'hFF;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      rd_cnt_q    <= 8'd0;
      wr_cnt_q    <= 8'd0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      polls_q     <= 8'd0;
    end else begin
      sclk_meta_q <= sdSCLK;  sclk_sync_q <= sclk_meta_q;  sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= sdMOSI;  mosi_sync_q <= mosi_meta_q;
      cs_meta_q   <= sdCS;    cs_sync_q   <= cs_meta_q;
      state_q     <= state_d;
      kind_q      <= kind_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      cmd_cnt_q   <= cmd_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      r1_q        <= r1_d;
      trail_q     <= trail_d;
      sector_q    <= sector_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rd_vld_q    <= rd_vld_d;
      rd_buf_q    <= rd_buf_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      idle_q      <= idle_d;
      app_q       <= app_d;
      polls_q     <= polls_d;
    end
  end

  assign sdMISO   = miso_q;
  assign memADDR  = mem_addr_q;
  assign memRD    = mem_rd_q;
  assign memWR    = mem_wr_q;
  assign memWDATA = mem_wdata_q;
  assign rdCNT    = rd_cnt_q;
  assign wrCNT    = wr_cnt_q;
  assign idle     = idle_q;
endmodule

// File: tb/tb_sd_spi_responder.sv
`timescale 1ns/1ps
// tb_sd_spi_responder
// Directed bench: an SPI host model (SCLK period 8 clk, high 3 / low 5) and a
// 4 KiB backing-store model preset to mem[i] = i & 0xFF while reset is low.
module tb_sd_spi_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sdSCLK = 1'b0;
  logic        sdMOSI = 1'b1;
  logic        sdCS = 1'b1;
  logic        sdMISO, memRD, memWR, idle;
  logic [23:0] memADDR;
  logic [7:0]  memRDATA, memWDATA, rdCNT, wrCNT;
  logic [7:0]  mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sd_spi_responder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sdSCLK   (sdSCLK),
    .sdMOSI   (sdMOSI),
    .sdCS     (sdCS),
    .sdMISO   (sdMISO),
    .memADDR  (memADDR),
    .memRD    (memRD),
    .memRDATA (memRDATA),
    .memWR    (memWR),
    .memWDATA (memWDATA),
    .rdCNT    (rdCNT),
    .wrCNT    (wrCNT),
    .idle     (idle)
  );

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
      memRDATA <= 8'h00;
    end else begin
      if (memRD) memRDATA <= mem[memADDR[11:0]];
      if (memWR) mem[memADDR[11:0]] <= memWDATA;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full-duplex byte, MSB first. MISO is sampled just before each rising edge.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      sdSCLK = 1'b0;
      sdMOSI = tx[i];
      repeat (5) @(posedge clk);
      #1;
      rx[i]  = sdMISO;
      sdSCLK = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, output logic [7:0] r1);
    logic [7:0] d;
    xfer({2'b01, idx}, d);
    for (int i = 3; i >= 0; i--) xfer(arg[8*i +: 8], d);
    xfer(8'h95, d);
    xfer(8'hFF, d);
    check("ncr_byte", d, 8'hFF);
    xfer(8'hFF, r1);
  endtask

  task automatic set_cs(input logic level);
    sdSCLK = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    sdCS = level;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b, r1;
    logic [7:0] exp8  [4];
    logic [7:0] exp58 [4];
    int errs;
    exp8  = '{8'h00, 8'h00, 8'h01, 8'hAA};
    exp58 = '{8'hC0, 8'hFF, 8'h80, 8'h00};

    // Reset values
    repeat (4) @(posedge clk);
    #1;
    check("rst_miso", sdMISO, 1'b1);
    check("rst_memrd", memRD, 1'b0);
    check("rst_memwr", memWR, 1'b0);
    check("rst_memaddr", memADDR, 24'h0);
    check("rst_memwdata", memWDATA, 8'h00);
    check("rst_rdcnt", rdCNT, 8'h00);
    check("rst_wrcnt", wrCNT, 8'h00);
    check("rst_idle", idle, 1'b1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    set_cs(1'b0);

    // Read while the card is still idle
    send_cmd(6'd17, 32'd5, r1);
    check("cmd17_idle_r1", r1, 8'h05);

    // Init sequence
    send_cmd(6'd0, 32'd0, r1);
    check("cmd0_r1", r1, 8'h01);
    send_cmd(6'd8, 32'h1AA, r1);
    check("cmd8_r1", r1, 8'h01);
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, b);
      check("cmd8_trail", b, exp8[i]);
    end
    for (int k = 0; k < 3; k++) begin
      send_cmd(6'd55, 32'd0, r1);
      check("cmd55_r1", r1, 8'h01);
      send_cmd(6'd41, 32'h4000_0000, r1);
      check("acmd41_r1", r1, (k < 2) ? 8'h01 : 8'h00);
      check("acmd41_idle", idle, (k < 2) ? 1'b1 : 1'b0);
    end

    send_cmd(6'd58, 32'd0, r1);
    check("cmd58_r1", r1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, b);
      check("cmd58_ocr", b, exp58[i]);
    end

    // Sector 5 read (preset to i & 0xFF)
    send_cmd(6'd17, 32'd5, r1);
    check("rd_r1", r1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, b);
      check("rd_wait_ff", b, 8'hFF);
    end
    xfer(8'hFF, b);
    check("rd_token", b, 8'hFE);
    errs = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, b);
      if (b !== 8'(i)) errs++;
      if (i == 0) check("rd_first_byte", b, 8'h00);
    end
    check("rd_data_errs", errs, 0);
    xfer(8'hFF, b);
    check("rd_crc0", b, 8'hFF);
    xfer(8'hFF, b);
    check("rd_crc1", b, 8'hFF);
    repeat (4) @(posedge clk);
    #1;
    check("rdcnt_after_read", rdCNT, 8'd1);

    // Sector 3 write of 0xA5
    send_cmd(6'd24, 32'd3, r1);
    check("wr_r1", r1, 8'h00);
    xfer(8'hFE, b);
    for (int i = 0; i < 512; i++) xfer(8'hA5, b);
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    check("wr_data_resp", b, 8'h05);
    for (int i = 0; i < 8; i++) begin
      xfer(8'hFF, b);
      check("wr_busy_00", b, 8'h00);
    end
    xfer(8'hFF, b);
    check("wr_after_busy", b, 8'hFF);
    check("wrcnt_after_write", wrCNT, 8'd1);
    errs = 0;
    for (int a = 12'h600; a < 12'h800; a++) if (mem[a] !== 8'hA5) errs++;
    check("wr_mem_errs", errs, 0);
    check("wr_mem_below", mem[12'h5FF], 8'hFF);
    check("wr_mem_above", mem[12'h800], 8'h00);

    // Out-of-range sector: 2^(24-9) = 0x8000
    send_cmd(6'd17, 32'h8000, r1);
    check("rd_oor_r1", r1, 8'h40);
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(8'hFF, b);
      if (b === 8'hFE) errs++;
    end
    check("rd_oor_no_token", errs, 0);
    check("rdcnt_after_oor", rdCNT, 8'd1);

    // Write into sector 7 abandoned by CS after 100 bytes
    send_cmd(6'd24, 32'd7, r1);
    check("wr_abort_r1", r1, 8'h00);
    xfer(8'hFE, b);
    for (int i = 0; i < 100; i++) xfer(8'h3C, b);
    set_cs(1'b1);
    check("wrcnt_after_abort", wrCNT, 8'd1);
    errs = 0;
    for (int a = 12'hE00; a < 12'hE64; a++) if (mem[a] !== 8'h3C) errs++;
    check("wr_abort_mem_errs", errs, 0);
    check("wr_abort_byte100", mem[12'hE64], 8'h64);
    set_cs(1'b0);
    send_cmd(6'd0, 32'd0, r1);
    check("cmd0_after_abort", r1, 8'h01);
    check("idle_after_cmd0", idle, 1'b1);

    // Reset in the middle of a command
    xfer(8'h48, b);
    xfer(8'h00, b);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_rdcnt", rdCNT, 8'd0);
    check("midrst_wrcnt", wrCNT, 8'd0);
    check("midrst_idle", idle, 1'b1);
    check("midrst_miso", sdMISO, 1'b1);
    check("midrst_memwr", memWR, 1'b0);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

SPI-mode SD card responder that answers the same command/data protocol the RK8E disk controller's SD host issues (CMD0, CMD8, CMD55/ACMD41, CMD58, CMD16, CMD17, CMD24). The block sits on the far side of the sdMISO/sdMOSI/sdSCLK/sdCS pins. It serves 512-byte sectors from an external byte-wide backing store, either block RAM or a simulation array. The block is used for simulation and for on-board loopback of the disk subsystem without a physical card.

## Interface
- ADDR_W, 24: backing-store byte-address width. Sector count is 2^(ADDR_W-9).
- INIT_POLLS, 2: number of ACMD41 commands answered 0x01 before the card reports ready with 0x00.
- RD_LATENCY, 4: number of 0xFF bytes sent between the CMD17 R1 byte and the 0xFE token.
- WR_BUSY, 8: number of 0x00 busy bytes sent after the write data-response byte.
- clk  in  1  system clock; must be ≥ 8× SCLK frequency.
- reset_n  in  1  reset, synchronous, active-low.
- sdSCLK  in  1  SPI clock from the host, mode 0.
- sdMOSI  in  1  host data into this block.
- sdCS  in  1  chip select, active-low.
- sdMISO  out  1  data to the host, MSB first.
- memADDR  out  ADDR_W  backing-store byte address.
- memRD  out  1  one-clk read strobe. memRDATA is valid on the next clk.
- memRDATA  in  8  read data.
- memWR  out  1  one-clk write strobe, qualified with memADDR and memWDATA.
- memWDATA  out  8  write data.
- rdCNT  out  8  completed CMD17 count; wraps at 255 to 0.
- wrCNT  out  8  completed CMD24 count; wraps at 255 to 0.
- idle  out  1  card idle flag, equal to R1 bit 0.

## Operation
**Pin conditioning**
- sdSCLK, sdMOSI and sdCS pass through 2-flop synchronisers.
- A rising SCLK edge samples MOSI into the RX shift register.
- A falling SCLK edge shifts the TX register onto MISO.

**Byte framing and chip select**
- After 8 rising edges a byte is complete, and the next TX byte is loaded with its MSB on MISO. The default TX byte is 0xFF.
- When CS is high: the bit counter clears, MISO is forced to 1, and the protocol FSM returns to CMD.
- Exception: a WR_BUSY countdown in progress continues to its end.

**FSM states and transitions**
- CMD: discards bytes until bits[7:6] = 01, then collects 6 bytes (index, 32-bit arg, CRC). CRC is ignored.
- NCR: one 0xFF byte.
- R1: sends the response byte.
- RX4: sends four trailing bytes, used by CMD8 and CMD58 only.
- Read path: RD_WAIT → RD_TOKEN → RD_DATA (512 bytes) → RD_CRC (2 bytes, both 0xFF). RD_CRC returns to CMD and increments rdCNT.
- Write path: WR_TOKEN → WR_DATA (512 bytes) → WR_CRC (2 bytes, discarded) → WR_RESP (0x05) → WR_BUSY → CMD. WR_RESP increments wrCNT.

**Command responses**
- CMD0: clears app flag and poll count, sets idle, R1 = 0x01.
- CMD8: R1 = idle flag, then 0x00 0x00 0x01 arg[7:0].
- CMD55: sets app flag; R1 = idle flag.
- ACMD41 (CMD41 with app flag set): increments poll count. R1 = 0x01 while count ≤ INIT_POLLS, else clears idle and returns 0x00.
- CMD58: R1, then 0xC0 0xFF 0x80 0x00 (CCS = 1, block addressing).
- CMD16: R1 only. The argument is ignored.
- Any command other than CMD55 clears the app flag after its response.
- Unknown command, or CMD17/CMD24 while idle: R1 = 0x04 | idle.
- CMD17/CMD24 with arg ≥ 2^(ADDR_W-9): R1 = 0x40 and no data phase.

**Addressing and backing store**
- memADDR = {arg[ADDR_W-10:0], 9'b0} + byte index, where the byte index runs 0..511.
- Read: memRD pulses on the rising edge of bit 0 of the byte preceding each data byte. memRDATA is registered into TX before that byte's boundary.
- Write: WR_TOKEN ignores 0xFF bytes. Byte 0xFE enters WR_DATA. Any other byte returns to CMD with no write.
- In WR_DATA, memWR pulses one clk after the 8th rising edge of each byte.
- During WR_BUSY, MOSI bytes are not parsed.

## Timing
**Reset values**
- sdMISO = 1, memRD = memWR = 0.
- memADDR = 0, memWDATA = 0.
- rdCNT = wrCNT = 0.
- idle = 1, FSM = CMD, app flag and poll count = 0.

**Latencies**
- Pin to internal edge: 3 clk.
- Response placement: the R1 byte is the 2nd byte clocked after the command's 6th byte (Ncr = 1).
- Read token: the 0xFE token is byte RD_LATENCY+1 after R1.

**Boundary conditions**
- CS deasserted mid-RD_DATA or mid-WR_DATA: the transfer is abandoned and the counter is not incremented. Bytes already written stay written.
- reset_n low mid-operation: all state is restored to reset values on the next clk.
- Write ordering: the 512th data byte is written before WR_CRC begins.

## Test plan
- Init sequence CMD0 → CMD8 (arg 0x1AA) → (CMD55, ACMD41) ×3 → required responses:
  - CMD0: 0x01.
  - CMD8: 01 00 00 01 AA.
  - ACMD41: 0x01, 0x01, then 0x00.
  - idle: falls after the third ACMD41.
- CMD58 after init → 00 C0 FF 80 00.
- Preload sector 5 with bytes i & 0xFF, then CMD17 arg 5 → required responses:
  - 00, then 4× FF, then FE.
  - 512 data bytes, 0x00..0xFF repeated, then FF FF.
  - rdCNT = 1.
- CMD24 arg 3, token FE, 512 bytes 0xA5, 2 CRC bytes → required responses:
  - 05, then 8× 00, then FF.
  - memory 0x600–0x7FF = A5.
  - wrCNT = 1.
- CMD17 before init → 0x05. CMD17 arg 2^(ADDR_W-9) → 0x40 with no FE token.
- CS raised after 100 bytes of CMD24 data → only 100 bytes written, wrCNT unchanged. The next CMD0 returns 0x01.
